inst_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter and issues requests to instruction memory over a req/ack handshake. Presents one fetched word with its PC and a valid flag to the decoder, honours decoder back-pressure through a one-entry skid register, and accepts PC redirects from the branch/jump resolution logic with flush of in-flight and buffered instructions.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/inst_fetch_skid.sv | 53 +++++
 rtl/inst_fetch.sv | 115 +++++++++++
 tb/tb_inst_fetch.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FAULT
  } fetch_state_t;
endpackage

// File: rtl/inst_fetch_skid.sv
// rtl/inst_fetch_skid.sv - decoder-facing output register backed by a one-entry skid register
module inst_fetch_skid
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_valid,
  output logic            skid_valid
);
  logic [XLEN-1:0] skid_inst;
  logic [XLEN-1:0] skid_pc;
  logic            consume;

  assign consume = out_valid && !stall;

  // load never coincides with a full skid: the fetcher stops requesting while it is occupied
  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst   <= NOP;
      out_pc     <= RESET_PC;
      out_valid  <= 1'b0;
      skid_inst  <= NOP;
      skid_pc    <= RESET_PC;
      skid_valid <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume && skid_valid) begin
      out_inst   <= skid_inst;
      out_pc     <= skid_pc;
      skid_valid <= 1'b0;
    end else if (load && (!out_valid || consume)) begin
      out_inst  <= in_inst;
      out_pc    <= in_pc;
      out_valid <= 1'b1;
    end else if (load) begin
      skid_inst  <= in_inst;
      skid_pc    <= in_pc;
      skid_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC, imem req/ack sequencing and redirect handling
// IFETCH_MISALIGN_EN enables the misaligned-target FAULT state.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemRdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_misaligned
);
  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  tgt;
  logic         tgt_mis;
  logic [31:0]  target;
  logic         mis;
  logic [31:0]  buf_pc;
  logic         skid_valid;
  logic         load;

`ifdef IFETCH_MISALIGN_EN
  assign target       = i_redirectPc;
  assign mis          = |i_redirectPc[1:0];
  assign o_misaligned = (state == FAULT);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^i_redirectPc[1:0];
  assign target          = {i_redirectPc[31:2], 2'b00};
  assign mis             = 1'b0;
  assign o_misaligned    = 1'b0;
`endif

  assign o_imemReq  = ((state == FETCH) && !skid_valid) || (state == DRAIN);
  assign o_imemAddr = pc;
  assign load       = (state == FETCH) && o_imemReq && i_imemAck && !i_redirect;
  assign o_pc       = (state == FAULT) ? pc : buf_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      tgt     <= RESET_PC;
      tgt_mis <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (i_redirect) begin
            pc    <= target;
            state <= mis ? FAULT : FETCH;
          end
        end
        FETCH: begin
          if (i_redirect) begin
            // an unacked request must complete before the PC can move
            if (o_imemReq && !i_imemAck) begin
              state   <= DRAIN;
              tgt     <= target;
              tgt_mis <= mis;
            end else begin
              pc    <= target;
              state <= mis ? FAULT : FETCH;
            end
          end else if (o_imemReq && i_imemAck) begin
            pc <= pc + 32'd4;
          end
        end
        DRAIN: begin
          if (i_redirect) begin
            tgt     <= target;
            tgt_mis <= mis;
          end
          if (i_imemAck) begin
            pc    <= i_redirect ? target : tgt;
            state <= (i_redirect ? mis : tgt_mis) ? FAULT : FETCH;
          end
        end
        FAULT: begin
          if (i_redirect) begin
            pc <= target;
            if (!mis) state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  inst_fetch_skid #(
    .RESET_PC(RESET_PC)
  ) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (load),
    .stall     (i_stall),
    .flush     (i_redirect),
    .in_inst   (i_imemRdata),
    .in_pc     (pc),
    .out_inst  (o_inst),
    .out_pc    (buf_pc),
    .out_valid (o_valid),
    .skid_valid(skid_valid)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with a behavioural memory and stream model
module tb_inst_fetch;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck;
  logic [31:0] i_imemRdata;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirectPc;
  logic        o_misaligned;

  int errors = 0;
  int checks = 0;

  int          lat = 0;
  int          wait_cnt = 0;
  bit          rand_lat = 0;
  logic [31:0] mem_key = 32'h0;

  logic        obs_req, obs_ack, obs_valid, obs_mis, obs_stall, obs_redirect;
  logic [31:0] obs_addr, obs_pc, obs_inst;
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_imemReq   (o_imemReq),
    .o_imemAddr  (o_imemAddr),
    .i_imemAck   (i_imemAck),
    .i_imemRdata (i_imemRdata),
    .o_inst      (o_inst),
    .o_pc        (o_pc),
    .o_valid     (o_valid),
    .i_stall     (i_stall),
    .i_redirect  (i_redirect),
    .i_redirectPc(i_redirectPc),
    .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ mem_key;
  endfunction

  // One bus cycle: memory answers, outputs are sampled, then the clock advances.
  task automatic cycle();
    if (o_imemReq) begin
      if (wait_cnt >= lat) begin
        i_imemAck   = 1'b1;
        i_imemRdata = memf(o_imemAddr);
        wait_cnt    = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        i_imemAck   = 1'b0;
        i_imemRdata = $urandom;
        wait_cnt++;
      end
    end else begin
      i_imemAck   = 1'b0;
      i_imemRdata = $urandom;
    end
    #1;
    obs_req      = o_imemReq;
    obs_addr     = o_imemAddr;
    obs_ack      = i_imemAck;
    obs_valid    = o_valid;
    obs_pc       = o_pc;
    obs_inst     = o_inst;
    obs_mis      = o_misaligned;
    obs_stall    = i_stall;
    obs_redirect = i_redirect;
    if (o_valid && !i_stall && !i_redirect) begin
      got_pc.push_back(o_pc);
      got_inst.push_back(o_inst);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst        = 1'b1;
    i_stall      = 1'b0;
    i_redirect   = 1'b0;
    i_redirectPc = 32'h0;
    i_imemAck    = 1'b0;
    i_imemRdata  = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst    = 1'b0;
    wait_cnt = 0;
    lat      = 0;
    rand_lat = 0;
    mem_key  = 32'h0;
    got_pc.delete();
    got_inst.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    checks++; if (o_imemReq !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", o_imemReq); end
    checks++; if (o_imemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", o_imemAddr); end
    checks++; if (o_inst !== 32'h0000_0013) begin errors++; $display("FAIL reset_inst got=%h exp=00000013", o_inst); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b exp=0", o_misaligned); end
    i_rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    apply_reset();
    cycle();
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL zw_idle_req got=%b exp=0", obs_req); end
    for (int c = 1; c <= 6; c++) begin
      cycle();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'(4 * (c - 1))) begin
        errors++; $display("FAIL zw_req c=%0d got=%b/%h exp=1/%h", c, obs_req, obs_addr, 32'(4 * (c - 1)));
      end
      checks++;
      if (c >= 2) begin
        if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * (c - 2)) || obs_inst !== 32'(4 * (c - 2))) begin
          errors++; $display("FAIL zw_out c=%0d got=%b/%h/%h exp=1/%h", c, obs_valid, obs_pc, obs_inst, 32'(4 * (c - 2)));
        end
      end else if (obs_valid !== 1'b0) begin
        errors++; $display("FAIL zw_first_valid got=%b exp=0", obs_valid);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    cycle();
    cycle();
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_inst !== 32'h0) begin
        errors++; $display("FAIL stall_hold k=%0d got=%b/%h/%h exp=1/0/0", k, obs_valid, obs_pc, obs_inst);
      end
      if (k > 0) begin
        checks++;
        if (obs_req !== 1'b0) begin errors++; $display("FAIL stall_req k=%0d got=%b exp=0", k, obs_req); end
      end
    end
    i_stall = 1'b0;
    repeat (4) cycle();
    checks++;
    if (got_pc.size() < 3) begin
      errors++; $display("FAIL stall_count got=%0d exp>=3", got_pc.size());
    end else begin
      for (int i = 0; i < got_pc.size(); i++) begin
        if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL stall_seq i=%0d got=%h/%h exp=%h", i, got_pc[i], got_inst[i], 32'(4 * i));
          break;
        end
      end
    end
  endtask

  task automatic test_redirect_drain();
    apply_reset();
    cycle();
    cycle();
    lat          = 3;
    i_redirect   = 1'b1;
    i_redirectPc = 32'h100;
    cycle();
    i_redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== 32'h4 || obs_valid !== 1'b0) begin
        errors++; $display("FAIL drain_hold k=%0d got=%b/%h/%b exp=1/4/0", k, obs_req, obs_addr, obs_valid);
      end
    end
    lat = 0;
    cycle();
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== 32'h100 || obs_valid !== 1'b0) begin
      errors++; $display("FAIL drain_target got=%b/%h/%b exp=1/100/0", obs_req, obs_addr, obs_valid);
    end
    repeat (3) cycle();
    checks++;
    if (got_pc.size() == 0 || got_pc[0] !== 32'h100 || got_inst[0] !== 32'h100) begin
      errors++; $display("FAIL drain_first got=%h exp=100 n=%0d", (got_pc.size() > 0) ? got_pc[0] : 32'hx, got_pc.size());
    end
  endtask

  task automatic test_redirect_skid();
    for (int v = 0; v < 2; v++) begin
      apply_reset();
      cycle();
      cycle();
      i_stall = 1'b1;
      if (v == 1) cycle();
      i_redirect   = 1'b1;
      i_redirectPc = 32'h200;
      cycle();
      i_redirect = 1'b0;
      cycle();
      checks++;
      if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200) begin
        errors++; $display("FAIL skid_redirect v=%0d got=%b/%b/%h exp=0/1/200", v, obs_valid, obs_req, obs_addr);
      end
      i_stall = 1'b0;
      repeat (3) cycle();
      checks++;
      if (got_pc.size() == 0 || got_pc[0] !== 32'h200 || got_inst[0] !== 32'h200) begin
        errors++; $display("FAIL skid_first v=%0d got=%h exp=200 n=%0d", v, (got_pc.size() > 0) ? got_pc[0] : 32'hx, got_pc.size());
      end
    end
  endtask

  task automatic test_misalign();
    int n_before;
    apply_reset();
    repeat (3) cycle();
    i_redirect   = 1'b1;
    i_redirectPc = 32'h102;
    cycle();
    i_redirect = 1'b0;
    n_before   = got_pc.size();
    for (int k = 0; k < 3; k++) begin
      cycle();
`ifdef IFETCH_MISALIGN_EN
      checks++;
      if (obs_mis !== 1'b1 || obs_pc !== 32'h102 || obs_req !== 1'b0 || obs_valid !== 1'b0) begin
        errors++; $display("FAIL fault_hold k=%0d got=%b/%h/%b/%b exp=1/102/0/0", k, obs_mis, obs_pc, obs_req, obs_valid);
      end
`else
      checks++;
      if (obs_mis !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'(32'h100 + 4 * k)) begin
        errors++; $display("FAIL nofault_fetch k=%0d got=%b/%b/%h exp=0/1/%h", k, obs_mis, obs_req, obs_addr, 32'(32'h100 + 4 * k));
      end
`endif
    end
`ifndef IFETCH_MISALIGN_EN
    checks++;
    if (got_pc.size() <= n_before || got_pc[n_before] !== 32'h100) begin
      errors++; $display("FAIL nofault_first got=%h exp=100", (got_pc.size() > n_before) ? got_pc[n_before] : 32'hx);
    end
`endif
    i_redirect   = 1'b1;
    i_redirectPc = 32'h300;
    cycle();
    i_redirect = 1'b0;
    n_before   = got_pc.size();
    cycle();
    checks++;
    if (obs_mis !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h300) begin
      errors++; $display("FAIL fault_clear got=%b/%b/%h exp=0/1/300", obs_mis, obs_req, obs_addr);
    end
    repeat (3) cycle();
    checks++;
    if (got_pc.size() <= n_before || got_pc[n_before] !== 32'h300) begin
      errors++; $display("FAIL fault_resume got=%h exp=300", (got_pc.size() > n_before) ? got_pc[n_before] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    for (int v = 0; v < 2; v++) begin
      apply_reset();
      cycle();
      cycle();
      if (v == 0) begin
        lat = 5;
        cycle();
        cycle();
        lat = 2;
      end else begin
        i_stall = 1'b1;
        cycle();
        cycle();
      end
      i_rst = 1'b1;
      cycle();
      i_rst   = 1'b0;
      i_stall = 1'b0;
      checks++;
      if (o_imemReq !== 1'b0 || o_imemAddr !== 32'h0 || o_inst !== 32'h0000_0013 ||
          o_pc !== 32'h0 || o_valid !== 1'b0 || o_misaligned !== 1'b0) begin
        errors++; $display("FAIL midreset v=%0d got=%b/%h/%h/%h/%b/%b exp=0/0/13/0/0/0",
                           v, o_imemReq, o_imemAddr, o_inst, o_pc, o_valid, o_misaligned);
      end
      wait_cnt = 0;
      lat      = 0;
      got_pc.delete();
      got_inst.delete();
      repeat (4) cycle();
      checks++;
      if (got_pc.size() == 0 || got_pc[0] !== 32'h0) begin
        errors++; $display("FAIL midreset_restart v=%0d got=%h exp=0", v, (got_pc.size() > 0) ? got_pc[0] : 32'hx);
      end
    end
  endtask

  // Consumed words must follow PC+4 from the most recent redirect target; pending requests keep their address.
  task automatic test_random();
    logic [31:0] exp_pc, raw, red_tgt, prev_addr;
    logic        prev_req, prev_ack, prev_redir;
    int          consumed, seq_err, hold_err, flush_err;
    apply_reset();
    rand_lat = 1;
    mem_key  = 32'hC0DE_5A00;
    lat      = $urandom_range(0, 3);
    exp_pc   = 32'h0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_redir = 1'b0; prev_addr = 32'h0;
    consumed = 0; seq_err = 0; hold_err = 0; flush_err = 0;
    for (int n = 0; n < 800; n++) begin
      i_stall    = ($urandom_range(0, 9) < 3);
      i_redirect = ($urandom_range(0, 24) == 0);
`ifdef IFETCH_MISALIGN_EN
      raw = 32'($urandom_range(0, 1023)) << 2;
`else
      raw = 32'($urandom_range(0, 4095));
`endif
      i_redirectPc = raw;
      red_tgt      = raw & 32'hFFFF_FFFC;
      cycle();
      i_redirect = 1'b0;
      if (prev_req && !prev_ack) begin
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== prev_addr) begin
          errors++; hold_err++;
          if (hold_err < 4) $display("FAIL rnd_hold n=%0d got=%b/%h exp=1/%h", n, obs_req, obs_addr, prev_addr);
        end
      end
      if (prev_redir) begin
        checks++;
        if (obs_valid !== 1'b0) begin
          errors++; flush_err++;
          if (flush_err < 4) $display("FAIL rnd_flush n=%0d got=%b exp=0", n, obs_valid);
        end
      end
      if (obs_redirect) begin
        exp_pc = red_tgt;
      end else if (obs_valid && !obs_stall) begin
        checks++;
        if (obs_pc !== exp_pc || obs_inst !== (exp_pc ^ mem_key)) begin
          errors++; seq_err++;
          if (seq_err < 4) $display("FAIL rnd_seq n=%0d got=%h/%h exp=%h/%h", n, obs_pc, obs_inst, exp_pc, exp_pc ^ mem_key);
          exp_pc = obs_pc;
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_req = obs_req; prev_ack = obs_ack; prev_addr = obs_addr; prev_redir = obs_redirect;
    end
    checks++;
    if (consumed < 50) begin errors++; $display("FAIL rnd_throughput got=%0d exp>=50", consumed); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_drain();
    test_redirect_skid();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
